mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Sits between the EX/MEM pipeline register and the byte-addressable data memory, on the memory-stage side. It takes one load/store request per cycle and drives the data memory port. Naturally aligned accesses pass straight through in the same cycle. A misaligned halfword or word access is split into sequential byte accesses, and the pipeline is stalled until the access completes.

Parameters:
ADDR_W, 6, byte-address width of the data memory port; all address arithmetic is modulo 2^ADDR_W.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
req_valid  input  1  memory-stage request present.
req_read  input  1  load request.
req_write  input  1  store request; wins over req_read if both are set.
req_addr  input  ADDR_W  byte address.
req_func3  input  3  RISC-V funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
req_wdata  input  32  store data.
stall  output  1  hold the memory stage and all upstream stages.
rsp_valid  output  1  access complete this cycle (loads and stores).
rsp_rdata  output  32  load result, extended per funct3; 0 for stores.
misaligned  output  1  one-cycle pulse on completion of a split access (for performance counting).
dm_MemRead  output  1  data memory read enable.
dm_MemWrite  output  1  data memory write enable (memory writes on the clock edge).
dm_addr  output  ADDR_W  data memory byte address.
dm_func3  output  3  data memory access size.
dm_data_in  output  32  data memory write data.
dm_data_out  input  32  combinational read data from data memory.

Behaviour:
- Access size N: 1 for funct3 000/100, 2 for 001/101, 4 for 010.
- Misaligned: N=2 with addr[0]=1, or N=4 with addr[1:0]≠0.
- Unsupported funct3 (011/110/111): no memory access. rsp_valid=1 with rsp_rdata=0 in the same cycle; stall=0.
- Stores accept only 000/001/010; any other funct3 on a store is treated as unsupported.
- Request stability: the upstream stage holds all req_* signals stable while stall=1 and through the following completion cycle.
- FSM states: IDLE, SPLIT, DONE. Byte counter k is 2 bits. Accumulator acc is 32 bits.
- IDLE, aligned or no request:
  - dm_* are driven combinationally from req_* (MemRead=req_valid&read&!write, MemWrite=req_valid&write).
  - rsp_valid=req_valid; rsp_rdata=dm_data_out for loads.
  - stall=0; zero added latency.
- IDLE, misaligned request:
  - stall=1 combinationally.
  - Issue byte 0 this cycle: dm_addr=req_addr, dm_func3=100 for a load or 000 for a store, dm_data_in[7:0]=req_wdata[7:0].
  - Load: acc[7:0] is captured from dm_data_out[7:0] at the edge.
  - k←1; next state SPLIT.
- SPLIT:
  - stall=1; issue byte k at dm_addr=req_addr+k (wraps modulo 2^ADDR_W).
  - Store data is req_wdata[8k+7:8k]; a load captures acc[8k+7:8k].
  - If k=N-1, go to DONE; else k←k+1.
- DONE:
  - stall=0, dm_MemRead=dm_MemWrite=0, rsp_valid=1, misaligned=1.
  - rsp_rdata for LH is {16{acc[15]}},acc[15:0]; for LHU it is 16'b0,acc[15:0]; for LW it is acc; for a store it is 0.
  - Next state is always IDLE. The request still present in this cycle is not re-issued.
- Latency for a misaligned N-byte access presented at cycle T:
  - stall=1 in cycles T..T+N-1.
  - rsp_valid in cycle T+N.
  - Exactly N byte writes for a store.
- dm_MemWrite is never asserted with req_valid=0 and never in DONE.
- Reset (rst=1 at an edge):
  - state←IDLE, k←0, acc←0.
  - rst=1 also forces all outputs to 0 that cycle: stall, rsp_valid, misaligned, dm_MemRead, dm_MemWrite.
  - Reset mid-split aborts the access. Bytes already written stay in memory; no further bytes are written.
- Outputs in IDLE with req_valid=0: all 0.

Test Plan:
- Memory bytes [0..3]=20,9,4,0; aligned LW at addr 0 -> same cycle rsp_valid=1, rsp_rdata=0x00040914, stall=0.
- Memory bytes [1..4]=09,04,00,AB; LW at addr 1 -> stall=1 for 4 cycles with dm_addr 1,2,3,4; then rsp_valid=1, rsp_rdata=0xAB000409, misaligned=1.
- SH at addr 3, wdata 0x00001234 -> 2 stall cycles; mem[3]=0x34, mem[4]=0x12; exactly 2 dm_MemWrite cycles; rsp_valid in the 3rd cycle.
- mem[5]=0x80, mem[6]=0xFF; LH at addr 5 -> 0xFFFFFF80; LHU at addr 5 -> 0x0000FF80; each completes with 2 stall cycles.
- ADDR_W=6, LW at addr 62 -> dm_addr sequence 62,63,0,1; result assembled little-endian.
- SW at addr 1 with wdata 0xDDCCBBAA and rst=1 during the second byte cycle -> only mem[1]=0xAA is written; next cycle stall=0 and state IDLE.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: passes aligned loads/stores straight to the data
// memory and splits misaligned halfword/word accesses into byte accesses.
// Ports: req_* request in, stall/rsp_*/misaligned out, dm_* data memory port.
module mem_access_unit #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_func3,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              misaligned,
  output logic              dm_MemRead,
  output logic              dm_MemWrite,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [2:0]        dm_func3,
  output logic [31:0]       dm_data_in,
  input  logic [31:0]       dm_data_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SPLIT,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [1:0]  k_q;
  logic [31:0] acc_q;

  logic       is_st;
  logic       is_ld;
  logic       ld_ok;
  logic       st_ok;
  logic       supp;
  logic       mis;
  logic [1:0] last_k;
  logic [4:0] k_bit;

  assign is_st = req_valid & req_write;
  assign is_ld = req_valid & req_read & ~req_write;

  always_comb begin
    ld_ok = 1'b0;
    st_ok = 1'b0;
    case (req_func3)
      3'b000, 3'b001, 3'b010: begin
        ld_ok = 1'b1;
        st_ok = 1'b1;
      end
      3'b100, 3'b101: ld_ok = 1'b1;
      default: ;
    endcase
  end

  assign supp = is_st ? st_ok : (is_ld & ld_ok);

  assign mis = supp &
    (((req_func3[1:0] == 2'b01) & req_addr[0]) |
     ((req_func3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00)));

  // Index of the final byte: 1 for halfwords, 3 for words.
  assign last_k = {req_func3[1], req_func3[1] | req_func3[0]};
  assign k_bit  = {k_q, 3'b000};

  always_comb begin
    stall       = 1'b0;
    rsp_valid   = 1'b0;
    rsp_rdata   = 32'b0;
    misaligned  = 1'b0;
    dm_MemRead  = 1'b0;
    dm_MemWrite = 1'b0;
    dm_addr     = req_addr;
    dm_func3    = req_func3;
    dm_data_in  = req_wdata;
    case (state_q)
      S_IDLE: begin
        if (mis) begin
          stall       = 1'b1;
          dm_MemRead  = is_ld;
          dm_MemWrite = is_st;
          dm_func3    = is_st ? 3'b000 : 3'b100;
          dm_data_in  = {24'b0, req_wdata[7:0]};
        end else begin
          rsp_valid   = req_valid;
          dm_MemRead  = supp & is_ld;
          dm_MemWrite = supp & is_st;
          if (supp & is_ld) rsp_rdata = dm_data_out;
        end
      end
      S_SPLIT: begin
        stall       = 1'b1;
        dm_addr     = req_addr + ADDR_W'(k_q);
        dm_MemRead  = is_ld;
        dm_MemWrite = is_st;
        dm_func3    = is_st ? 3'b000 : 3'b100;
        dm_data_in  = {24'b0, req_wdata[k_bit +: 8]};
      end
      S_DONE: begin
        rsp_valid  = 1'b1;
        misaligned = 1'b1;
        if (is_ld) begin
          case (req_func3)
            3'b001:  rsp_rdata = {{16{acc_q[15]}}, acc_q[15:0]};
            3'b101:  rsp_rdata = {16'b0, acc_q[15:0]};
            3'b010:  rsp_rdata = acc_q;
            default: rsp_rdata = 32'b0;
          endcase
        end
      end
      default: ;
    endcase
    // Reset wins over everything so an aborted split writes no more bytes.
    if (rst) begin
      stall       = 1'b0;
      rsp_valid   = 1'b0;
      misaligned  = 1'b0;
      dm_MemRead  = 1'b0;
      dm_MemWrite = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= 2'd0;
      acc_q   <= 32'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mis) begin
            if (is_ld) acc_q[7:0] <= dm_data_out[7:0];
            k_q     <= 2'd1;
            state_q <= S_SPLIT;
          end
        end
        S_SPLIT: begin
          if (is_ld) acc_q[k_bit +: 8] <= dm_data_out[7:0];
          if (k_q == last_k) begin
            state_q <= S_DONE;
          end else begin
            k_q <= k_q + 2'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          k_q     <= 2'd0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-addressed memory model plus an
// expected-result queue checked as each access completes.
module tb_mem_access_unit;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_read, req_write;
  logic [AW-1:0] req_addr;
  logic [2:0]    req_func3;
  logic [31:0]   req_wdata;
  logic          stall, rsp_valid, misaligned;
  logic [31:0]   rsp_rdata;
  logic          dm_MemRead, dm_MemWrite;
  logic [AW-1:0] dm_addr;
  logic [2:0]    dm_func3;
  logic [31:0]   dm_data_in, dm_data_out;

  mem_access_unit #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_func3(req_func3), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .misaligned(misaligned),
    .dm_MemRead(dm_MemRead), .dm_MemWrite(dm_MemWrite),
    .dm_addr(dm_addr), .dm_func3(dm_func3),
    .dm_data_in(dm_data_in), .dm_data_out(dm_data_out)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [64];
  logic [7:0] b0, b1, b2, b3;

  always_comb begin
    b0 = mem[dm_addr];
    b1 = mem[dm_addr + 6'd1];
    b2 = mem[dm_addr + 6'd2];
    b3 = mem[dm_addr + 6'd3];
    case (dm_func3)
      3'b000:  dm_data_out = {{24{b0[7]}}, b0};
      3'b100:  dm_data_out = {24'b0, b0};
      3'b001:  dm_data_out = {{16{b1[7]}}, b1, b0};
      3'b101:  dm_data_out = {16'b0, b1, b0};
      3'b010:  dm_data_out = {b3, b2, b1, b0};
      default: dm_data_out = 32'b0;
    endcase
  end

  always @(posedge clk) begin
    if (dm_MemWrite) begin
      mem[dm_addr] <= dm_data_in[7:0];
      if (dm_func3[1:0] != 2'b00) mem[dm_addr + 6'd1] <= dm_data_in[15:8];
      if (dm_func3[1:0] == 2'b10) begin
        mem[dm_addr + 6'd2] <= dm_data_in[23:16];
        mem[dm_addr + 6'd3] <= dm_data_in[31:24];
      end
    end
  end

  int passed = 0;
  int total  = 0;
  logic [31:0]   exp_q [$];
  logic [AW-1:0] addr_q [$];

  int          st, wr;
  logic [31:0] rd, ex;
  logic        ms, got;

  // Drives one request and collects what the DUT did until it responds.
  task automatic do_access(input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [2:0] f3,
                           input logic [31:0] wd,
                           output int stalls, output int writes,
                           output logic [31:0] rdata, output logic mis,
                           output logic seen);
    req_valid = 1'b1;
    req_read  = r;
    req_write = w;
    req_addr  = a;
    req_func3 = f3;
    req_wdata = wd;
    stalls = 0;
    writes = 0;
    rdata  = 32'b0;
    mis    = 1'b0;
    seen   = 1'b0;
    addr_q.delete();
    for (int c = 0; c < 16 && !seen; c++) begin
      @(negedge clk);
      if (dm_MemWrite) writes++;
      if (rsp_valid) begin
        seen  = 1'b1;
        rdata = rsp_rdata;
        mis   = misaligned;
      end else if (stall) begin
        stalls++;
        addr_q.push_back(dm_addr);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go_idle();
    req_valid = 1'b0;
    req_read  = 1'b0;
    req_write = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b1;
    req_read  = 1'b1;
    req_write = 1'b0;
    req_addr  = 6'd1;
    req_func3 = 3'b010;
    @(negedge clk);
    total++;
    if ({stall, rsp_valid, misaligned, dm_MemRead, dm_MemWrite} !== 5'b0)
      $display("FAIL reset_outputs got %b want 00000",
               {stall, rsp_valid, misaligned, dm_MemRead, dm_MemWrite});
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({stall, rsp_valid, misaligned, dm_MemRead, dm_MemWrite} !== 5'b0)
      $display("FAIL idle_outputs got %b want 00000",
               {stall, rsp_valid, misaligned, dm_MemRead, dm_MemWrite});
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_aligned_load();
    mem[0] = 8'd20; mem[1] = 8'd9; mem[2] = 8'd4; mem[3] = 8'd0;
    exp_q.push_back(32'h0004_0914);
    do_access(1, 0, 6'd0, 3'b010, 32'h0, st, wr, rd, ms, got);
    ex = exp_q.pop_front();
    total++;
    if (!got || st != 0) $display("FAIL al_lw_lat got stalls=%0d rsp=%b want 0/1", st, got);
    else passed++;
    total++;
    if (rd !== ex) $display("FAIL al_lw_data got %h want %h", rd, ex);
    else passed++;
    total++;
    if (ms !== 1'b0) $display("FAIL al_lw_mis got %b want 0", ms);
    else passed++;
    go_idle();
  endtask

  task automatic test_mis_word();
    mem[4] = 8'hAB;
    exp_q.push_back(32'hAB00_0409);
    do_access(1, 0, 6'd1, 3'b010, 32'h0, st, wr, rd, ms, got);
    ex = exp_q.pop_front();
    total++;
    if (!got || st != 4) $display("FAIL lw1_stalls got %0d rsp=%b want 4/1", st, got);
    else passed++;
    total++;
    if ({addr_q[0], addr_q[1], addr_q[2], addr_q[3]} !== {6'd1, 6'd2, 6'd3, 6'd4})
      $display("FAIL lw1_addrs got %0d %0d %0d %0d want 1 2 3 4",
               addr_q[0], addr_q[1], addr_q[2], addr_q[3]);
    else passed++;
    total++;
    if (rd !== ex || ms !== 1'b1) $display("FAIL lw1_data got %h mis=%b want %h mis=1", rd, ms, ex);
    else passed++;
    go_idle();
  endtask

  task automatic test_mis_store();
    mem[3] = 8'h00; mem[4] = 8'h00; mem[5] = 8'h77;
    exp_q.push_back(32'h0);
    do_access(0, 1, 6'd3, 3'b001, 32'h0000_1234, st, wr, rd, ms, got);
    ex = exp_q.pop_front();
    total++;
    if (!got || st != 2) $display("FAIL sh3_stalls got %0d rsp=%b want 2/1", st, got);
    else passed++;
    total++;
    if (wr != 2) $display("FAIL sh3_writes got %0d want 2", wr);
    else passed++;
    total++;
    if ({mem[3], mem[4], mem[5]} !== 24'h34_12_77)
      $display("FAIL sh3_mem got %h %h %h want 34 12 77", mem[3], mem[4], mem[5]);
    else passed++;
    total++;
    if (rd !== ex || ms !== 1'b1) $display("FAIL sh3_rsp got %h mis=%b want %h mis=1", rd, ms, ex);
    else passed++;
    go_idle();
  endtask

  task automatic test_back_to_back();
    mem[5] = 8'h80; mem[6] = 8'hFF;
    exp_q.push_back(32'hFFFF_FF80);
    exp_q.push_back(32'h0000_FF80);
    do_access(1, 0, 6'd5, 3'b001, 32'h0, st, wr, rd, ms, got);
    ex = exp_q.pop_front();
    total++;
    if (!got || st != 2 || rd !== ex)
      $display("FAIL lh5 got %h stalls=%0d rsp=%b want %h/2/1", rd, st, got, ex);
    else passed++;
    do_access(1, 0, 6'd5, 3'b101, 32'h0, st, wr, rd, ms, got);
    ex = exp_q.pop_front();
    total++;
    if (!got || st != 2 || rd !== ex)
      $display("FAIL lhu5 got %h stalls=%0d rsp=%b want %h/2/1", rd, st, got, ex);
    else passed++;
    go_idle();
  endtask

  task automatic test_wrap();
    mem[62] = 8'h11; mem[63] = 8'h22; mem[0] = 8'h14; mem[1] = 8'h09;
    exp_q.push_back(32'h0914_2211);
    do_access(1, 0, 6'd62, 3'b010, 32'h0, st, wr, rd, ms, got);
    ex = exp_q.pop_front();
    total++;
    if ({addr_q[0], addr_q[1], addr_q[2], addr_q[3]} !== {6'd62, 6'd63, 6'd0, 6'd1})
      $display("FAIL wrap_addrs got %0d %0d %0d %0d want 62 63 0 1",
               addr_q[0], addr_q[1], addr_q[2], addr_q[3]);
    else passed++;
    total++;
    if (!got || rd !== ex) $display("FAIL wrap_data got %h rsp=%b want %h", rd, got, ex);
    else passed++;
    go_idle();
  endtask

  task automatic test_unsupported();
    mem[8] = 8'h5A;
    exp_q.push_back(32'h0);
    do_access(1, 0, 6'd8, 3'b011, 32'h0, st, wr, rd, ms, got);
    ex = exp_q.pop_front();
    total++;
    if (!got || st != 0 || rd !== ex)
      $display("FAIL unsup_ld got %h stalls=%0d rsp=%b want %h/0/1", rd, st, got, ex);
    else passed++;
    exp_q.push_back(32'h0);
    do_access(0, 1, 6'd8, 3'b100, 32'hFF, st, wr, rd, ms, got);
    ex = exp_q.pop_front();
    total++;
    if (!got || wr != 0 || mem[8] !== 8'h5A || rd !== ex)
      $display("FAIL unsup_st got writes=%0d mem=%h rsp=%b want 0/5a/1", wr, mem[8], got);
    else passed++;
    exp_q.push_back(32'h0);
    do_access(0, 1, 6'd8, 3'b010, 32'hA1B2C3D4, st, wr, rd, ms, got);
    ex = exp_q.pop_front();
    total++;
    if (!got || st != 0 || wr != 1 || rd !== ex)
      $display("FAIL al_sw got stalls=%0d writes=%0d rsp=%b want 0/1/1", st, wr, got);
    else passed++;
    go_idle();
    total++;
    if ({mem[11], mem[10], mem[9], mem[8]} !== 32'hA1B2C3D4)
      $display("FAIL al_sw_mem got %h want a1b2c3d4", {mem[11], mem[10], mem[9], mem[8]});
    else passed++;
  endtask

  task automatic test_reset_abort();
    mem[0] = 8'h14; mem[1] = 8'h00;
    mem[2] = 8'h55; mem[3] = 8'h55; mem[4] = 8'h55;
    req_valid = 1'b1;
    req_read  = 1'b0;
    req_write = 1'b1;
    req_addr  = 6'd1;
    req_func3 = 3'b010;
    req_wdata = 32'hDDCCBBAA;
    @(negedge clk);
    total++;
    if (stall !== 1'b1 || dm_MemWrite !== 1'b1 || dm_data_in[7:0] !== 8'hAA)
      $display("FAIL abort_b0 got st=%b we=%b d=%h want 1/1/aa", stall, dm_MemWrite, dm_data_in[7:0]);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({stall, dm_MemWrite, rsp_valid} !== 3'b000)
      $display("FAIL abort_rst got %b want 000", {stall, dm_MemWrite, rsp_valid});
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({stall, rsp_valid} !== 2'b00) $display("FAIL abort_after got %b want 00", {stall, rsp_valid});
    else passed++;
    total++;
    if ({mem[1], mem[2], mem[3], mem[4]} !== 32'hAA_55_55_55)
      $display("FAIL abort_mem got %h %h %h %h want aa 55 55 55", mem[1], mem[2], mem[3], mem[4]);
    else passed++;
    @(posedge clk);
    #1;
    exp_q.push_back(32'h5555_AA14);
    do_access(1, 0, 6'd0, 3'b010, 32'h0, st, wr, rd, ms, got);
    ex = exp_q.pop_front();
    total++;
    if (!got || st != 0 || rd !== ex)
      $display("FAIL abort_idle got %h stalls=%0d rsp=%b want %h/0/1", rd, st, got, ex);
    else passed++;
    go_idle();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    rst = 1'b1;
    req_valid = 1'b0;
    req_read  = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_func3 = 3'b000;
    req_wdata = 32'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_aligned_load();
    test_mis_word();
    test_mis_store();
    test_back_to_back();
    test_wrap();
    test_unsupported();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
